// File: rtl/car_tracking_pkg.sv
// Shared types and constants for the parking-lot car-tracking controller:
// scan-state encoding, datapath widths and the sweep address lookup.
package car_tracking_pkg;

    localparam int CAR_W  = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [3:0] {
        S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13
    } scan_state_t;

    // Read address presented while in a sweep state: climbs 2..7 then falls back to 0.
    // S0 is handled by the caller because it depends on start.
    function automatic logic [ADDR_W-1:0] scan_addr(input scan_state_t s);
        logic [ADDR_W-1:0] a;
        a = '0;
        if (s >= S1 && s <= S6) begin
            a = ADDR_W'(s) + ADDR_W'(1);
        end else if (s >= S7) begin
            a = ADDR_W'(4'd13 - 4'(s));
        end
        return a;
    endfunction

endpackage

// File: rtl/car_tracking_ram_ctrl_if.sv
// User-input / display-side bundle of the car-tracking controller.
// master: debounced input logic driving the controller; slave: the controller.
interface car_tracking_ram_ctrl_if;
    import car_tracking_pkg::*;

    logic              hour;
    logic              car_in;
    logic              start;
    logic              wr_en;
    logic [CAR_W-1:0]  out;
    logic [CAR_W-1:0]  car_count;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] hour_count;

    modport master (
        output hour, car_in, start, wr_en,
        input  out, car_count, read_address, hour_count
    );

    modport slave (
        input  hour, car_in, start, wr_en,
        output out, car_count, read_address, hour_count
    );
endinterface

// File: rtl/car_tracking_ram_ctrl_ram8x16.sv
// ram8x16: 8 x 16 simple dual-port RAM, synchronous write, registered read data.
// Read data is captured before the write lands, so a same-address collision
// returns the old word. Contents power up to zero and are never reset.
module ram8x16
    import car_tracking_pkg::*;
(
    input  logic              clock,
    input  logic [CAR_W-1:0]  data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [CAR_W-1:0]  q
);

    logic [CAR_W-1:0] mem_q [DEPTH] = '{default: '0};
    logic [CAR_W-1:0] q_q = '0;

    // Write port and registered read port share the single clock.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem_q[wraddress] <= data;
        end
        q_q <= mem_q[rdaddress];
    end

    assign q = q_q;

endmodule

// File: rtl/car_tracking_ram_ctrl.sv
// car_tracking_ram_ctrl: car/hour counters, per-hour RAM store and a
// ping-pong read-address sweep (0->7->0) for the display.
// Optional macro SLOW_SCAN_EN: sweep advances once per 2**DIV_BITS cycles
// via a clock enable; otherwise it advances every cycle.
module car_tracking_ram_ctrl
    import car_tracking_pkg::*;
#(
    parameter int DIV_BITS = 26
) (
    input  logic                  clock,
    input  logic                  reset,
    car_tracking_ram_ctrl_if.slave bus
);

    logic [CAR_W-1:0]  car_count_q, car_count_d;
    logic [ADDR_W-1:0] hour_count_q, hour_count_d;
    scan_state_t       ps_q, ns_d;
    logic [ADDR_W-1:0] rd_addr;
    logic [CAR_W-1:0]  ram_q;
    logic              out_valid_q;
    logic              step;

`ifdef SLOW_SCAN_EN
    logic [DIV_BITS-1:0] div_q;

    // Free-running divider; its wrap is the scan enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_q + DIV_BITS'(1);
    end

    assign step = &div_q;
`else
    // Divider absent: the sweep steps on every cycle.
    assign step = 1'b1 | (DIV_BITS < 0);
`endif

    // Counter next-state: each pulse advances by one, natural wrap.
    always_comb begin
        car_count_d  = car_count_q + (bus.car_in ? CAR_W'(1) : CAR_W'(0));
        hour_count_d = hour_count_q + (bus.hour ? ADDR_W'(1) : ADDR_W'(0));
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            car_count_q  <= '0;
            hour_count_q <= '0;
        end else begin
            car_count_q  <= car_count_d;
            hour_count_q <= hour_count_d;
        end
    end

    // Scan state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ps_q <= S0;
        else       ps_q <= ns_d;
    end

    // Scan next-state and read address; start only matters while idle.
    always_comb begin
        ns_d    = ps_q;
        rd_addr = scan_addr(ps_q);
        if (ps_q == S0) begin
            rd_addr = '0;
            if (step && bus.start) begin
                ns_d    = S1;
                rd_addr = ADDR_W'(1);
            end
        end else if (step) begin
            ns_d = (ps_q == S13) ? S0 : scan_state_t'(4'(ps_q) + 4'd1);
        end
    end

    // Masks stale RAM read data until the first read after reset completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) out_valid_q <= 1'b0;
        else       out_valid_q <= 1'b1;
    end

    ram8x16 u_ram (
        .clock     (clock),
        .data      (car_count_q),
        .rdaddress (rd_addr),
        .wraddress (hour_count_q),
        .wren      (bus.wr_en),
        .q         (ram_q)
    );

    assign bus.out          = out_valid_q ? ram_q : '0;
    assign bus.car_count    = car_count_q;
    assign bus.read_address = rd_addr;
    assign bus.hour_count   = hour_count_q;

endmodule

// File: tb/tb_car_tracking_ram_ctrl.sv
// Self-checking bench for car_tracking_ram_ctrl (default build, every-cycle scan).
module tb_car_tracking_ram_ctrl;
    import car_tracking_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    car_tracking_ram_ctrl_if bus ();

    car_tracking_ram_ctrl #(.DIV_BITS(26)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: counters, memory image, expected read data and the
    // list of addresses still to come in the current sweep.
    int unsigned m_car;
    int unsigned m_hour;
    int unsigned m_mem [8];
    int unsigned m_out;
    int unsigned sweep_q [$];
    int unsigned sweep_tail [13];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model.
    task automatic step_cycle(input bit h, input bit c, input bit s, input bit w, input bit verbose);
        int unsigned exp_addr;
        bus.hour   = h;
        bus.car_in = c;
        bus.start  = s;
        bus.wr_en  = w;
        #1;
        exp_addr = (sweep_q.size() == 0) ? (s ? 1 : 0) : sweep_q[0];
        check("read_address", bus.read_address, exp_addr);
        check("car_count",    bus.car_count,    m_car);
        check("hour_count",   bus.hour_count,   m_hour);
        check("out",          bus.out,          m_out);
        if (verbose)
            $display("cyc %0d hour=%0b car_in=%0b start=%0b wr_en=%0b -> addr=%0d out=%0h car=%0h hr=%0d",
                     cyc, h, c, s, w, bus.read_address, bus.out, bus.car_count, bus.hour_count);
        @(posedge clock);
        m_out = m_mem[exp_addr];
        if (w) m_mem[m_hour] = m_car;
        if (c) m_car = (m_car + 1) % 65536;
        if (h) m_hour = (m_hour + 1) % 8;
        if (sweep_q.size() != 0) void'(sweep_q.pop_front());
        else if (s) foreach (sweep_tail[k]) sweep_q.push_back(sweep_tail[k]);
        cyc++;
        @(negedge clock);
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        bus.hour   = 1'b0;
        bus.car_in = 1'b0;
        bus.start  = 1'b0;
        bus.wr_en  = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst_car_count",    bus.car_count,    0);
        check("rst_hour_count",   bus.hour_count,   0);
        check("rst_read_address", bus.read_address, 0);
        check("rst_out",          bus.out,          0);
        $display("cyc %0d reset asserted -> car=%0h hr=%0d addr=%0d out=%0h",
                 cyc, bus.car_count, bus.hour_count, bus.read_address, bus.out);
        m_car  = 0;
        m_hour = 0;
        m_out  = 0;
        sweep_q.delete();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        sweep_tail = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
        foreach (m_mem[k]) m_mem[k] = 0;
        m_car = 0; m_hour = 0; m_out = 0;
        bus.hour = 1'b0; bus.car_in = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
        @(negedge clock);
        do_reset();

        // First writes at hour 0 and the hour/car advance.
        step_cycle(0, 1, 0, 1, 1);
        step_cycle(1, 1, 0, 1, 1);
        step_cycle(0, 0, 0, 0, 1);

        // Full sweep and settle back to idle.
        step_cycle(0, 0, 1, 0, 1);
        for (int i = 0; i < 15; i++) step_cycle(0, 0, 0, 0, 1);

        // Hour wrap 7 -> 0 over eight pulses.
        for (int i = 0; i < 8; i++) step_cycle(1, 0, 0, 1, 1);

        // Simultaneous hour and car pulse; start toggled during a sweep.
        step_cycle(1, 1, 0, 0, 1);
        step_cycle(0, 0, 1, 0, 1);
        for (int i = 0; i < 14; i++) step_cycle(0, 0, bit'(i % 2), 0, 1);
        for (int i = 0; i < 20 && sweep_q.size() != 0; i++) step_cycle(0, 0, 0, 0, 1);

        // Read/write collision at address 3.
        for (int i = 0; i < 8 && m_hour != 3; i++) step_cycle(1, 0, 0, 0, 1);
        step_cycle(0, 1, 1, 0, 1);
        step_cycle(0, 1, 0, 0, 1);
        step_cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) step_cycle(0, 0, 0, 0, 1);

        // Randomized traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step_cycle(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                       bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 2) == 0), 1);
        end

        // Run car_count up to FFFF quietly, then wrap to 0000.
        for (int i = 0; i < 70000 && m_car != 16'hFFFF; i++) step_cycle(0, 1, 0, 0, 0);
        check("reach_ffff", bus.car_count, 16'hFFFF);
        step_cycle(0, 1, 0, 1, 1);
        step_cycle(0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
